// File: rtl/dm_responder.sv
// dm_responder: wait-state data memory behind a valid/ready handshake for the MEM stage
module dm_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              stall
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_nxt;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be_q;
   logic [31:0]       mem [2**ADDR_W];
   logic [31:0]       merged;
   logic              access;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   always_comb begin
      state_nxt  = state == IDLE ? (req_valid ? WAIT : IDLE) :
                   state == WAIT ? (cnt == '0 ? RESP : WAIT) : IDLE;
      req_ready  = state == IDLE;
      resp_valid = state == RESP;
      stall      = (state == IDLE && req_valid) || state == WAIT;
      access     = state == WAIT && cnt == '0;
      for (int i = 0; i < 4; i++)
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem[addr_q][8*i +: 8];
   end
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         cnt        <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         resp_rdata <= '0;
      end else if (state == IDLE && req_valid) begin
         cnt     <= 4'(LATENCY);
         addr_q  <= req_addr;
         we_q    <= req_we;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end else if (state == WAIT) begin
         cnt <= cnt - (cnt != '0 ? 4'd1 : 4'd0);
         if (access) resp_rdata <= we_q ? merged : mem[addr_q];
      end
   // reset forces IDLE, so an aborted store never reaches this write
   always_ff @(posedge CLK)
      if (access && we_q) mem[addr_q] <= merged;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed and random accesses on LATENCY 0/1/2 responders against a word-array model
module tb_dm_responder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        rv [3];
   logic        we [3];
   logic [9:0]  ad [3];
   logic [31:0] wd [3];
   logic [3:0]  be [3];
   logic        rdy [3];
   logic        rsv [3];
   logic [31:0] rd [3];
   logic        st [3];
   int errors = 0;
   int checks = 0;
   logic [31:0] model [int];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      dm_responder #(.ADDR_W(10), .LATENCY(g)) u_dut (
         .CLK(clk), .RST(rst_n),
         .req_valid(rv[g]), .req_we(we[g]), .req_addr(ad[g]),
         .req_wdata(wd[g]), .req_be(be[g]),
         .req_ready(rdy[g]), .resp_valid(rsv[g]), .resp_rdata(rd[g]), .stall(st[g])
      );
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? d[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction
   // one full access on responder sel; latency of responder sel equals sel
   task automatic access(input int sel, input logic w, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] b, input bit hold);
      int key = sel * 1024 + int'(a);
      logic [31:0] old = model.exists(key) ? model[key] : 32'h0;
      logic [31:0] exp = w ? merge(old, d, b) : old;
      if (w) model[key] = exp;
      @(posedge clk); #1;
      rv[sel] = 1'b1; we[sel] = w; ad[sel] = a; wd[sel] = d; be[sel] = b;
      for (int k = 0; k <= sel + 2; k++) begin
         @(negedge clk);
         chk($sformatf("ready[%0d] k=%0d", sel, k), 32'(rdy[sel]), 32'(k == 0));
         chk($sformatf("stall[%0d] k=%0d", sel, k), 32'(st[sel]), 32'(k <= sel + 1));
         chk($sformatf("resp_valid[%0d] k=%0d", sel, k), 32'(rsv[sel]), 32'(k == sel + 2));
      end
      chk($sformatf("rdata[%0d] a=%0d", sel, a), rd[sel], exp);
      if (!hold) begin
         @(posedge clk); #1;
         rv[sel] = 1'b0;
      end
   endtask
   initial begin
      for (int i = 0; i < 3; i++) begin
         rv[i] = 1'b0; we[i] = 1'b0; ad[i] = '0; wd[i] = '0; be[i] = '0;
      end
      rst_n = 1'b0;
      rv[1] = 1'b1;
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("rst ready", 32'(rdy[i]), 32'd1);
         chk("rst resp_valid", 32'(rsv[i]), 32'd0);
         chk("rst rdata", rd[i], 32'h0);
         chk("rst stall", 32'(st[i]), 32'(i == 1));
      end
      rv[1] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      // reset abort on LATENCY=2
      access(2, 1'b1, 10'd5, 32'h11111111, 4'hf, 1'b0);
      @(posedge clk); #1;
      rv[2] = 1'b1; we[2] = 1'b1; ad[2] = 10'd5; wd[2] = 32'hDEADBEEF; be[2] = 4'hf;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort ready", 32'(rdy[2]), 32'd1);
      chk("abort resp_valid", 32'(rsv[2]), 32'd0);
      chk("abort rdata", rd[2], 32'h0);
      chk("abort stall", 32'(st[2]), 32'd1);
      rv[2] = 1'b0;
      #1;
      chk("abort stall idle", 32'(st[2]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      access(2, 1'b0, 10'd5, 32'h0, 4'h0, 1'b0);
      // store/load latency
      access(2, 1'b1, 10'd3, 32'h12345678, 4'hf, 1'b0);
      access(2, 1'b0, 10'd3, 32'h0, 4'h0, 1'b0);
      // byte enables
      access(2, 1'b1, 10'd7, 32'hAABBCCDD, 4'hf, 1'b0);
      access(2, 1'b1, 10'd7, 32'h00000011, 4'b0001, 1'b0);
      access(2, 1'b0, 10'd7, 32'h0, 4'h0, 1'b0);
      access(2, 1'b1, 10'd7, 32'h55667788, 4'b1010, 1'b0);
      access(2, 1'b0, 10'd7, 32'h0, 4'h0, 1'b0);
      chk("byte merge", model[2 * 1024 + 7], 32'h55BB7711);
      // zero latency
      access(0, 1'b1, 10'd9, 32'h0BADF00D, 4'hf, 1'b0);
      access(0, 1'b0, 10'd9, 32'h0, 4'h0, 1'b0);
      // back-to-back with req_valid held high
      access(1, 1'b1, 10'd1, 32'h10101010, 4'hf, 1'b1);
      access(1, 1'b1, 10'd2, 32'h20202020, 4'hf, 1'b1);
      access(1, 1'b1, 10'd3, 32'h30303030, 4'hf, 1'b1);
      access(1, 1'b0, 10'd1, 32'h0, 4'h0, 1'b1);
      access(1, 1'b0, 10'd2, 32'h0, 4'h0, 1'b1);
      access(1, 1'b0, 10'd3, 32'h0, 4'h0, 1'b0);
      // top address must not alias word 0
      access(2, 1'b1, 10'd0, 32'h01234567, 4'hf, 1'b0);
      access(2, 1'b1, 10'd1023, 32'hCAFEF00D, 4'hf, 1'b0);
      access(2, 1'b0, 10'd1023, 32'h0, 4'h0, 1'b0);
      access(2, 1'b0, 10'd0, 32'h0, 4'h0, 1'b0);
      // random traffic over a small address pool
      repeat (40) begin
         int s = int'($urandom_range(0, 2));
         logic [9:0] a = $urandom_range(0, 3) == 0 ? 10'd1023 : 10'($urandom_range(0, 15));
         logic w = 1'($urandom_range(0, 1));
         logic [3:0] b = 4'($urandom_range(0, 15));
         if (!model.exists(s * 1024 + int'(a))) begin
            w = 1'b1;
            b = 4'hf;
         end
         access(s, w, a, $urandom, b, 1'($urandom_range(0, 1)));
         @(posedge clk); #1;
         rv[s] = 1'b0;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the pipelined CPU. It serves load/store requests from the datapath's MEM stage through a valid/ready handshake with a configurable wait-state latency. While an access is in flight it drives `stall` back to the pipeline, and it returns read data (or a write acknowledge) on a one-cycle `resp_valid` pulse. It replaces the single-cycle DM behind the EX_MEM/MEM_WB registers and is the memory-side end of the MEM-stage interface.

## Interface
- `ADDR_W`, 10, word-address width; depth is 2^ADDR_W words of 32 bits.
- `LATENCY`, 2, extra wait cycles per access; legal range 0..15 (4-bit counter).

- `CLK` in 1: system clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `req_valid` in 1: MEM stage presents an access.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: word address (ALU result bits [ADDR_W+1:2]).
- `req_wdata` in 32: store data (ReadData2 of the MEM stage).
- `req_be` in 4: byte enables for stores; bit i covers byte i (bits 8i+7:8i). Ignored on loads.
- `req_ready` out 1: responder can accept a request this cycle.
- `resp_valid` out 1: one-cycle pulse; access complete.
- `resp_rdata` out 32: load data, or the merged stored word on a store.
- `stall` out 1: freeze PC, IF_ID, ID_EX and EX_MEM.

## Operation
- FSM states: IDLE, WAIT, RESP. 4-bit counter `cnt`. Request registers capture `addr`, `we`, `wdata` and `be`.
- **IDLE:** `req_ready`=1.
  - If `req_valid`=1: capture the request, set `cnt`<=LATENCY, go to WAIT.
- **WAIT:** `req_ready`=0.
  - If `cnt`!=0: decrement `cnt`.
  - If `cnt`=0: perform the access at this edge, then go to RESP.
    - Store: `mem[addr]` byte i <= `wdata` byte i where `be[i]`=1; other bytes are kept. `resp_rdata` <= the merged word.
    - Load: `resp_rdata` <= `mem[addr]`.
- **RESP:** `resp_valid`=1, `req_ready`=0. Go to IDLE unconditionally. A request present in this cycle is not accepted; it is accepted in the following IDLE cycle.
- `stall` is combinational: (IDLE and `req_valid`) or WAIT. It is low in RESP so the pipeline advances on that edge.
- The pipeline holds the `req_*` signals stable while `stall`=1. The responder does not re-sample them after acceptance.
- `req_addr` uses all ADDR_W bits, so no out-of-range address exists. Address 2^ADDR_W−1 is the last word; it does not alias onto word 0.

## Timing
- Reset values (RST=0, asynchronous):
  - state = IDLE, `cnt`=0.
  - `req_ready`=1, `resp_valid`=0, `resp_rdata`=0.
  - `stall` follows `req_valid`.
  - Memory contents are not reset.
- Latency: a request accepted in cycle c0 produces `resp_valid` in cycle c0+LATENCY+2. `stall` is high in cycles c0..c0+LATENCY+1.
- Throughput: one access per LATENCY+3 cycles with `req_valid` held high.
- Store visibility: a load accepted after the store's RESP cycle returns the new data.
- Reset during WAIT:
  - If asserted before the access edge, the access is aborted and memory is unchanged.
  - If asserted during RESP, the store has already been committed.
- `resp_rdata` holds its value until the next access completes.

## Test plan
- **Reset abort:** Preload `mem[5]`=0x11111111, LATENCY=2. Issue store 0xDEADBEEF with `be`=1111 to address 5. Pull RST low in the first WAIT cycle. Required: immediately IDLE with `resp_valid`=0; after release, a load of address 5 returns 0x11111111.
- **Store/load latency:** LATENCY=2. Store 0x12345678 with `be`=1111 to address 3 at c0. Required: `stall`=1 in c0..c3 and `resp_valid`=1 only in c4. Then load address 3: `resp_rdata`=0x12345678.
- **Byte enables:** Preload `mem[7]`=0xAABBCCDD.
  - Store 0x00000011 with `be`=0001; load returns 0xAABBCC11.
  - Then store 0x55667788 with `be`=1010; load returns 0x55BB7711.
- **Zero latency:** LATENCY=0. Load at c0. Required: `resp_valid` in c2, `req_ready`=0 in c1..c2, `stall`=1 in c0..c1.
- **Back-to-back:** LATENCY=1. Hold `req_valid` high across three loads (addresses 1, 2, 3) as the pipeline advances. Required: acceptances at c0, c4 and c8; `resp_valid` at c3, c7 and c11; no acceptance ever occurs in a RESP cycle.
- **Top address:** Store 0xCAFEF00D to address 1023. Required: a load of address 1023 returns 0xCAFEF00D, and a load of address 0 returns its preloaded value unchanged.
